// File: rtl/spi_rx_byte_writer.sv
// SPI-slave byte receiver: oversampled sck/mosi/ena, one active-low write strobe per byte with sequential 11-bit address.
// Optional SPI_RX_MSB_FIRST_EN: first received bit lands in recv_d[7] instead of recv_d[0].
module spi_rx_byte_writer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck_i,
  input  logic        mosi_i,
  input  logic        ena_i,
  output logic [7:0]  recv_d,
  output logic [10:0] recv_a,
  output logic        n_recv_buf_we,
  output logic        recv_ovf
);

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ena_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, mosi_s, ena_s, sck_event;

  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        done_q, done_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  data_q, data_d;
  logic [10:0] addr_q, addr_d;
  logic        we_n_q, we_n_d;
  logic        ovf_q, ovf_d;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ena_s     = ena_sync_q[SYNC_STAGES-1];
  assign sck_event = sck_s & ~sck_prev_q;

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    if (sck_event && ena_s) begin
`ifdef SPI_RX_MSB_FIRST_EN
      shift_d = {shift_q[6:0], mosi_s};
`else
      shift_d = {mosi_s, shift_q[7:1]};
`endif
      bit_cnt_d = bit_cnt_q + 3'd1;
      done_d    = (bit_cnt_q == 3'd7);
    end
  end

  // Byte write happens the cycle after the 8th bit lands in shift_q.
  always_comb begin
    data_d     = data_q;
    addr_d     = addr_q;
    we_n_d     = 1'b1;
    byte_cnt_d = byte_cnt_q;
    if (done_q) begin
      data_d     = shift_q;
      addr_d     = byte_cnt_q[10:0];
      we_n_d     = 1'b0;
      byte_cnt_d = byte_cnt_q + 12'd1;
    end
    ovf_d = ovf_q | byte_cnt_q[11];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ena_sync_q  <= '0;
      sck_prev_q  <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      done_q      <= 1'b0;
      byte_cnt_q  <= 12'd0;
      data_q      <= 8'h00;
      addr_q      <= 11'd0;
      we_n_q      <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ena_sync_q  <= {ena_sync_q[SYNC_STAGES-2:0], ena_i};
      sck_prev_q  <= sck_s;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
      byte_cnt_q  <= byte_cnt_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      we_n_q      <= we_n_d;
      ovf_q       <= ovf_d;
    end
  end

  assign recv_d        = data_q;
  assign recv_a        = addr_q;
  assign n_recv_buf_we = we_n_q;
  assign recv_ovf      = ovf_q;

endmodule

// File: tb/tb_spi_rx_byte_writer.sv
// Bench for spi_rx_byte_writer: byte table, enable gaps, mid-byte reset, strobe latency, 2049-byte wrap/overflow.
module tb_spi_rx_byte_writer;
  localparam int SYNC  = 2;
  localparam int SYNC3 = 3;

  logic clk = 1'b0;
  logic rst, sck_i, mosi_i, ena_i;
  logic [7:0]  recv_d, recv_d3;
  logic [10:0] recv_a, recv_a3;
  logic        n_we, n_we3, ovf, ovf3;

  always #5 clk = ~clk;

  spi_rx_byte_writer #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sck_i(sck_i), .mosi_i(mosi_i), .ena_i(ena_i),
    .recv_d(recv_d), .recv_a(recv_a), .n_recv_buf_we(n_we), .recv_ovf(ovf));

  spi_rx_byte_writer #(.SYNC_STAGES(SYNC3)) dut3 (
    .clk(clk), .rst(rst), .sck_i(sck_i), .mosi_i(mosi_i), .ena_i(ena_i),
    .recv_d(recv_d3), .recv_a(recv_a3), .n_recv_buf_we(n_we3), .recv_ovf(ovf3));

  typedef struct { logic [7:0] d; logic [10:0] a; logic chk_ovf; } exp_t;
  typedef struct { logic [7:0] bits; logic [7:0] lsb; logic [7:0] msb; } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vt[7];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] exp_addr;
  int          byte_idx;
  logic        prev_we = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_of(input logic [7:0] bits);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = bits[i];
`ifdef SPI_RX_MSB_FIRST_EN
    return r;
`else
    return bits;
`endif
  endfunction

  task automatic push_exp(input logic [7:0] d);
    exp_t e;
    e.d       = d;
    e.a       = exp_addr;
    e.chk_ovf = (byte_idx < 2048);
    sb.push_back(e);
    exp_addr = exp_addr + 11'd1;
    byte_idx++;
  endtask

  // One SCK period: 2 clk low (data set up), 2 clk high.
  task automatic bit_tx(input logic b, input logic en);
    @(negedge clk); mosi_i = b; ena_i = en; sck_i = 1'b0;
    @(negedge clk);
    @(negedge clk); sck_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] bits, input logic [7:0] exp);
    push_exp(exp);
    for (int i = 0; i < 8; i++) bit_tx(bits[i], 1'b1);
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && sb.size() != 0; c++) @(negedge clk);
    chk("drain_empty", (sb.size() == 0), 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); sck_i = 1'b0; mosi_i = 1'b0; ena_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sb.delete();
    exp_addr = 11'd0;
    byte_idx = 0;
  endtask

  // Scoreboard monitor: every strobe must be expected, single-cycle, and match.
  always @(negedge clk) begin
    if (rst !== 1'b1 && n_we === 1'b0) begin
      chk("strobe_width", prev_we, 1);
      chk("strobe_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("recv_d", recv_d, mon_e.d);
        chk("recv_a", recv_a, mon_e.a);
        if (mon_e.chk_ovf) chk("ovf_low", ovf, 0);
      end
    end
    prev_we = n_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat2, lat3;
    logic [7:0] d3cap, b;

    vt[0] = '{8'hA5, 8'hA5, 8'hA5};
    vt[1] = '{8'h01, 8'h01, 8'h80};
    vt[2] = '{8'h80, 8'h80, 8'h01};
    vt[3] = '{8'hFF, 8'hFF, 8'hFF};
    vt[4] = '{8'h3C, 8'h3C, 8'h3C};
    vt[5] = '{8'h6C, 8'h6C, 8'h36};
    vt[6] = '{8'h12, 8'h12, 8'h48};

    rst = 1'b1; sck_i = 1'b0; mosi_i = 1'b0; ena_i = 1'b0;
    exp_addr = 11'd0; byte_idx = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_recv_d", recv_d, 8'h00);
    chk("rst_recv_a", recv_a, 0);
    chk("rst_we", n_we, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_recv_a3", recv_a3, 0);
    chk("rst_ovf3", ovf3, 0);

    // Table: consecutive bytes at addresses 0..6
    for (int i = 0; i < 7; i++) begin
`ifdef SPI_RX_MSB_FIRST_EN
      send_byte(vt[i].bits, vt[i].msb);
`else
      send_byte(vt[i].bits, vt[i].lsb);
`endif
    end
    drain();
`ifdef SPI_RX_MSB_FIRST_EN
    chk("hold_recv_d", recv_d, vt[6].msb);
`else
    chk("hold_recv_d", recv_d, vt[6].lsb);
`endif
    chk("hold_recv_a", recv_a, 6);
    chk("idle_we", n_we, 1);

    // Enable gap: disabled SCK pulses carry ones that must not enter the byte
    do_reset();
    b = 8'h6C;
    push_exp(exp_of(b));
    for (int i = 0; i < 4; i++) bit_tx(b[i], 1'b1);
    for (int i = 0; i < 10; i++) bit_tx(1'b1, 1'b0);
    for (int i = 4; i < 8; i++) bit_tx(b[i], 1'b1);
    drain();

    // Reset mid-byte discards partial bits
    do_reset();
    for (int i = 0; i < 5; i++) bit_tx(1'b1, 1'b1);
    do_reset();
    send_byte(8'h3C, exp_of(8'h3C));
    drain();

    // Strobe latency from the 8th sck_i rise, both sync depths
    do_reset();
    b = 8'h12;
    push_exp(exp_of(b));
    for (int i = 0; i < 7; i++) bit_tx(b[i], 1'b1);
    @(negedge clk); mosi_i = b[7]; sck_i = 1'b0;
    @(negedge clk);
    @(negedge clk); sck_i = 1'b1;
    lat2 = -1; lat3 = -1; d3cap = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (lat2 < 0 && n_we === 1'b0) lat2 = c;
      if (lat3 < 0 && n_we3 === 1'b0) begin lat3 = c; d3cap = recv_d3; end
    end
    chk("latency_sync2", lat2, SYNC + 2);
    chk("latency_sync3", lat3, SYNC3 + 2);
    chk("sync3_recv_d", d3cap, exp_of(b));
    @(negedge clk); sck_i = 1'b0;
    drain();

    // 2049 bytes: address wraps to 0, overflow flag sets and sticks
    do_reset();
    for (int k = 0; k < 2049; k++) begin
      b = k[7:0];
      send_byte(b, exp_of(b));
    end
    drain();
    chk("ovf_set", ovf, 1);
    chk("wrap_recv_a", recv_a, 0);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", ovf, 1);
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
